// File: rtl/can_frame_display_seq_pkg.sv
// Shared page indices, FSM states and frame bundle for the CAN frame display sequencer.
// Also provides helpers for the last page of a frame and the byte shown on a given page.
package can_frame_display_seq_pkg;

    localparam logic [3:0] PG_ID_HI    = 4'd0;
    localparam logic [3:0] PG_ID_LO    = 4'd1;
    localparam logic [3:0] PG_DLC      = 4'd2;
    localparam logic [3:0] PG_DATA0    = 4'd3;
    localparam logic [3:0] PG_MAX      = 4'd10;
    localparam logic [3:0] CAN_MAX_DLC = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    typedef struct packed {
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
    } can_frame_t;

    // DLC 9..15 still carries only 8 data bytes
    function automatic logic [3:0] last_page(input logic [3:0] dlc);
        logic [3:0] lp;
        if (dlc >= CAN_MAX_DLC)
            lp = PG_MAX;
        else
            lp = PG_DLC + dlc;
        return lp;
    endfunction

    function automatic logic [7:0] page_byte(
        input can_frame_t f,
        input logic [3:0] pg
    );
        logic [7:0] b;
        logic [2:0] k;
        k = 3'(pg - PG_DATA0);
        case (pg)
            PG_ID_HI: b = {5'b0, f.id[10:8]};
            PG_ID_LO: b = f.id[7:0];
            PG_DLC:   b = {4'h0, f.dlc};
            default:  b = f.data[{k, 3'b000} +: 8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/can_frame_display_seq_btn_sync_edge.sv
// Button synchroniser (SYNC_STAGES flops) followed by a one-cycle rising-edge pulse.
// Ports: CLK, RST_N (async, active low), btn_raw (asynchronous), btn_rise (pulse).
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn_raw,
    output logic btn_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign btn_rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/can_frame_display_seq.sv
// Holds the latest CAN frame and pages through it one byte at a time for a hex display.
// Ports: CLK/RST_N, RX_* valid/ready frame input, AUTO_EN, BTN_NEXT; DISP_BYTE, PAGE_IDX, FRAME_CNT.
module can_frame_display_seq
    import can_frame_display_seq_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RX_VALID,
    output logic        RX_READY,
    input  logic [10:0] RX_ID,
    input  logic [3:0]  RX_DLC,
    input  logic [63:0] RX_DATA,
    input  logic        AUTO_EN,
    input  logic        BTN_NEXT,
    output logic [7:0]  DISP_BYTE,
    output logic [3:0]  PAGE_IDX,
    output logic [7:0]  FRAME_CNT
);

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

    state_t     state_q, state_d;
    can_frame_t disp_q, disp_d;
    can_frame_t pend_q, pend_d;
    logic       pend_full_q, pend_full_d;
    logic [3:0] page_q, page_d;
    logic [31:0] dwell_q, dwell_d;
    logic [7:0] cnt_q;
    logic [7:0] byte_q, byte_d;

    logic       btn_rise;
    logic       accept;
    logic       tick;
    logic       adv;
    can_frame_t rx_frame;

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .btn_raw  (BTN_NEXT),
        .btn_rise (btn_rise)
    );

    assign rx_frame = {RX_ID, RX_DLC, RX_DATA};
    assign accept   = RX_VALID & ~pend_full_q;
    assign tick     = AUTO_EN & (dwell_q == DWELL_LAST);
    // timer and button landing together still give one advance
    assign adv      = (state_q == ST_SHOW) & (tick | btn_rise);

    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        page_d      = page_q;
        dwell_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    disp_d  = rx_frame;
                    page_d  = PG_ID_HI;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (adv) begin
                    if (page_q < last_page(disp_q.dlc)) begin
                        page_d = page_q + 4'd1;
                    end else begin
                        page_d = PG_ID_HI;
                        if (pend_full_q) begin
                            disp_d      = pend_q;
                            pend_full_d = 1'b0;
                        end
                    end
                end else if (AUTO_EN) begin
                    dwell_d = dwell_q + 32'd1;
                end
                // accept only happens with the slot empty, so it never races a wrap-load
                if (accept) begin
                    pend_d      = rx_frame;
                    pend_full_d = 1'b1;
                end
            end
            default: ;
        endcase
        byte_d = (state_d == ST_SHOW) ? page_byte(disp_d, page_d) : 8'h00;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            page_q      <= PG_ID_HI;
            dwell_q     <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
        end else begin
            state_q     <= state_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            page_q      <= page_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_q + {7'b0, accept};
            byte_q      <= byte_d;
        end
    end

    assign RX_READY  = ~pend_full_q;
    assign DISP_BYTE = byte_q;
    assign PAGE_IDX  = page_q;
    assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_can_frame_display_seq.sv
// Testbench for can_frame_display_seq: directed scenarios plus random traffic against a page-list model.
// Ports: none.
module tb_can_frame_display_seq;

    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic        CLK      = 1'b0;
    logic        RST_N    = 1'b0;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic [10:0] RX_ID    = '0;
    logic [3:0]  RX_DLC   = '0;
    logic [63:0] RX_DATA  = '0;
    logic        AUTO_EN  = 1'b0;
    logic        BTN_NEXT = 1'b0;
    logic [7:0]  DISP_BYTE;
    logic [3:0]  PAGE_IDX;
    logic [7:0]  FRAME_CNT;

    always #5 CLK = ~CLK;

    can_frame_display_seq #(
        .DWELL_CYCLES (DW),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .RX_ID     (RX_ID),
        .RX_DLC    (RX_DLC),
        .RX_DATA   (RX_DATA),
        .AUTO_EN   (AUTO_EN),
        .BTN_NEXT  (BTN_NEXT),
        .DISP_BYTE (DISP_BYTE),
        .PAGE_IDX  (PAGE_IDX),
        .FRAME_CNT (FRAME_CNT)
    );

    typedef struct packed {
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
    } frm_t;

    typedef logic [7:0] bq_t[$];

    int n_chk  = 0;
    int n_fail = 0;

    frm_t       m_cur, m_pend;
    bit         m_pv, m_show, m_acc;
    int         m_page, m_tick;
    logic [7:0] m_cnt;
    logic [7:0] m_bh;

    // the list of bytes a frame is shown as, in page order
    function automatic bq_t pages_of(input frm_t f);
        bq_t q;
        int  n;
        n = (f.dlc > 4'd8) ? 8 : int'(f.dlc);
        q.push_back({5'b0, f.id[10:8]});
        q.push_back(f.id[7:0]);
        q.push_back({4'h0, f.dlc});
        for (int k = 0; k < n; k++)
            q.push_back(f.data[8*k +: 8]);
        return q;
    endfunction

    function automatic void m_reset();
        m_cur  = '0;
        m_pend = '0;
        m_pv   = 0;
        m_show = 0;
        m_acc  = 0;
        m_page = 0;
        m_tick = 0;
        m_cnt  = '0;
        m_bh   = '0;
    endfunction

    function automatic void m_clock();
        bq_t  pg;
        bit   bedge, adv, acc;
        frm_t rx;
        rx    = {RX_ID, RX_DLC, RX_DATA};
        acc   = RX_VALID && !m_pv;
        // button edge becomes visible SYNC cycles after the raw level is sampled
        bedge = m_bh[SYNC-1] && !m_bh[SYNC];
        m_bh  = {m_bh[6:0], BTN_NEXT};
        pg    = pages_of(m_cur);
        if (!m_show) begin
            if (acc) begin
                m_cur  = rx;
                m_page = 0;
                m_tick = 0;
                m_show = 1;
            end
        end else begin
            adv = (AUTO_EN && m_tick == DW - 1) || bedge;
            if (adv) begin
                m_tick = 0;
                if (m_page < pg.size() - 1) begin
                    m_page++;
                end else begin
                    m_page = 0;
                    if (m_pv) begin
                        m_cur = m_pend;
                        m_pv  = 0;
                    end
                end
            end else begin
                m_tick = AUTO_EN ? m_tick + 1 : 0;
            end
            if (acc) begin
                m_pend = rx;
                m_pv   = 1;
            end
        end
        if (acc) m_cnt++;
        m_acc = acc;
    endfunction

    function automatic logic [7:0] m_disp();
        bq_t pg;
        if (!m_show) return 8'h00;
        pg = pages_of(m_cur);
        return pg[m_page];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        if (!RST_N) m_reset();
        else m_clock();
        #1;
        check("outs", {11'b0, DISP_BYTE, PAGE_IDX, FRAME_CNT, RX_READY},
              {11'b0, m_disp(), 4'(m_page), m_cnt, !m_pv});
    endtask

    task automatic send_frame(input frm_t f);
        bit done;
        done     = 0;
        RX_ID    = f.id;
        RX_DLC   = f.dlc;
        RX_DATA  = f.data;
        RX_VALID = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (m_acc) done = 1;
        end
        RX_VALID = 1'b0;
        check("send_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic press();
        BTN_NEXT = 1'b1;
        repeat (3) step();
        BTN_NEXT = 1'b0;
        repeat (4) step();
    endtask

    logic [7:0] seq_a [6];
    logic [7:0] seq_b [6];
    logic [3:0] pg_b  [6];
    frm_t       fd, fe;
    int         max_d, max_e;
    bit         found;

    initial begin
        m_reset();
        seq_a = '{8'h05, 8'hA3, 8'h02, 8'h11, 8'h22, 8'h05};
        seq_b = '{8'h23, 8'h01, 8'h7E, 8'h01, 8'h23, 8'h01};
        pg_b  = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2};

        repeat (3) step();
        RST_N = 1'b1;
        repeat (5) step();
        check("reset_ready", {31'b0, RX_READY}, 32'd1);
        check("reset_disp", {24'b0, DISP_BYTE}, 32'h00);

        // auto paging of a two-byte frame
        AUTO_EN = 1'b1;
        send_frame({11'h5A3, 4'd2, 48'h0, 8'h22, 8'h11});
        for (int i = 0; i < 6; i++) begin
            check("auto_seq", {24'b0, DISP_BYTE}, {24'b0, seq_a[i]});
            if (i < 5) repeat (DW) step();
        end

        // next frame waits in pending, then button-only paging
        send_frame({11'h123, 4'd1, 56'h0, 8'h7E});
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (DISP_BYTE === 8'h01) found = 1;
        end
        check("load_123", {31'b0, found}, 32'd1);
        AUTO_EN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            press();
            check("btn_byte", {24'b0, DISP_BYTE}, {24'b0, seq_b[i]});
            check("btn_page", {28'b0, PAGE_IDX}, {28'b0, pg_b[i]});
        end
        repeat (30) step();
        check("no_timer", {28'b0, PAGE_IDX}, 32'd2);

        // B fills pending, C stalls until B is shown
        AUTO_EN = 1'b1;
        send_frame({11'h2BC, 4'd3, 40'h0, 24'h333231});
        check("b_pend", {31'b0, RX_READY}, 32'd0);
        RX_ID    = 11'h444;
        RX_DLC   = 4'd2;
        RX_DATA  = 64'h5566;
        RX_VALID = 1'b1;
        repeat (10) step();
        check("c_stall", {24'b0, FRAME_CNT}, 32'd3);
        send_frame({11'h444, 4'd2, 48'h0, 16'h5566});
        check("b_shown", {24'b0, DISP_BYTE}, 32'h02);
        check("b_page0", {28'b0, PAGE_IDX}, 32'd0);
        check("c_accept", {24'b0, FRAME_CNT}, 32'd4);

        // DLC above 8 clamps the data pages; DLC 0 has no data pages
        fd = {11'h7FF, 4'd13, 64'h8877665544332211};
        fe = {11'h0AB, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        send_frame(fd);
        send_frame(fe);
        max_d = 0;
        max_e = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (m_cur == fd && int'(PAGE_IDX) > max_d) max_d = int'(PAGE_IDX);
            if (m_cur == fe && int'(PAGE_IDX) > max_e) max_e = int'(PAGE_IDX);
        end
        check("dlc13_last", max_d, 32'd10);
        check("dlc0_last", max_e, 32'd2);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            RX_VALID = ($urandom % 4 == 0);
            RX_ID    = 11'($urandom);
            RX_DLC   = 4'($urandom);
            RX_DATA  = {$urandom, $urandom};
            if ($urandom % 50 == 0) AUTO_EN = ~AUTO_EN;
            if ($urandom % 6 == 0) BTN_NEXT = ~BTN_NEXT;
            step();
        end
        RX_VALID = 1'b0;
        BTN_NEXT = 1'b0;
        AUTO_EN  = 1'b1;
        repeat (6) step();

        // asynchronous reset with a frame pending
        send_frame({11'h321, 4'd4, 32'h0, 32'hCAFEF00D});
        check("pend_full", {31'b0, RX_READY}, 32'd0);
        repeat (3) step();
        #3;
        RST_N = 1'b0;
        #1;
        check("arst_disp", {24'b0, DISP_BYTE}, 32'h00);
        check("arst_page", {28'b0, PAGE_IDX}, 32'd0);
        check("arst_cnt", {24'b0, FRAME_CNT}, 32'd0);
        check("arst_ready", {31'b0, RX_READY}, 32'd1);
        m_reset();
        #2;
        RST_N = 1'b1;
        repeat (3) step();

        // frame counter wraps after 256 transfers
        for (int i = 0; i < 256; i++)
            send_frame({11'(i), 4'd0, 64'h0});
        check("cnt_wrap", {24'b0, FRAME_CNT}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
